mem_sequencer: RTL

// - Bus sequencer between CPU and synchronous-write/combinational-read RAM; converts single-word CPU req/ack transactions into RAM cycles.
// - Inserts programmable wait states and masks addresses to RAM depth. Optionally detects the simulation-stop store.

---
 rtl/mem_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_sequencer.sv
// mem_sequencer: CPU req/ack to sync-write/comb-read RAM sequencer.
// Optional stop-store detect enabled by MEM_STOP_DETECT_EN.
module mem_sequencer #(
  parameter int            WAIT_STATES = 1,
  parameter logic [15:31]  ADDR_MASK   = 17'h1ff,
  parameter logic [15:31]  STOP_ADDR   = 17'h00100,
  parameter logic [0:31]   STOP_DATA   = 32'h00010001
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [15:31]  cpu_addr,
  input  logic [0:31]   cpu_wdata,
  output logic          cpu_ack,
  output logic [0:31]   cpu_rdata,
  output logic          busy,
  output logic [15:31]  mem_addr,
  output logic          mem_we,
  output logic [0:31]   mem_wdata,
  input  logic [0:31]   mem_rdata
`ifdef MEM_STOP_DETECT_EN
  ,
  output logic          sim_end
`endif
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
    $error("mem_sequencer: WAIT_STATES must be 0..15");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t        state;
  state_t        state_n;
  logic [3:0]    cnt;
  logic          we_q;
  logic          we_n;
  logic          mwe_q;
  logic [15:31]  addr_q;
  logic [0:31]   wdata_q;
  logic [0:31]   rdata_q;
  logic          take;

  assign take = (state == S_IDLE) && cpu_req;
  assign we_n = take ? cpu_we : we_q;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (cpu_req)
          state_n = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      end
      S_WAIT: begin
        if (cnt == 4'd1) state_n = S_ACCESS;
      end
      S_ACCESS: state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Request capture and wait-state countdown
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (take) begin
        cnt     <= WS;
        we_q    <= cpu_we;
        addr_q  <= cpu_addr & ADDR_MASK;
        wdata_q <= cpu_wdata;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Write strobe is its own flop so it cannot glitch
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) mwe_q <= 1'b0;
    else        mwe_q <= (state_n == S_ACCESS) && we_n;
  end

  // Read data captured on the ACCESS exit edge, held otherwise
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      rdata_q <= '0;
    else if (state == S_ACCESS && !we_q)
      rdata_q <= mem_rdata;
  end

`ifdef MEM_STOP_DETECT_EN
  // Sticky flag on the magic stop store
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      sim_end <= 1'b0;
    else if (state == S_ACCESS && we_q &&
             addr_q == STOP_ADDR &&
             wdata_q == STOP_DATA)
      sim_end <= 1'b1;
  end
`endif

  assign cpu_ack   = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign cpu_rdata = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_we    = mwe_q;
  assign mem_wdata = wdata_q;

endmodule
